serial_add_sequencer: RTL and testbench

//  Bit-serial add sequencer: streams two WIDTH-bit operands LSB-first through one

---
 rtl/serial_add_sequencer.sv | 119 +++++++++++
 tb/tb_serial_add_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sequencer.sv
// rtl/serial_add_sequencer.sv - bit-serial A+B+ci sequencer around one external full adder
// Optional SERIAL_SUB_EN adds the sub port (A-B via inverted B and forced carry-in).
module serial_add_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_ci,
    input  logic             fa_sum,
    input  logic             fa_co
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             carry_q, carry_d;
    // Low for the first cycle after reset so in_ready stays 0 in that cycle.
    logic             live_q;

    logic run;
    logic done;

    assign run  = (state_q == S_RUN);
    assign done = (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && live_q) begin
                    a_d     = a;
                    cnt_d   = '0;
                    state_d = S_RUN;
`ifdef SERIAL_SUB_EN
                    b_d     = sub ? ~b : b;
                    carry_d = sub | ci;
`else
                    b_d     = b;
                    carry_d = ci;
`endif
                end
            end
            S_RUN: begin
                s_d     = {fa_sum, s_q[WIDTH-1:1]};
                carry_d = fa_co;
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            live_q  <= 1'b1;
        end
    end

    assign in_ready  = live_q && (state_q == S_IDLE);
    assign out_valid = done;
    assign sum       = done ? s_q : '0;
    assign co        = done & carry_q;
    assign fa_a      = run & a_q[0];
    assign fa_b      = run & b_q[0];
    assign fa_ci     = run & carry_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb/tb_serial_add_sequencer.sv - self-checking bench for serial_add_sequencer
// Define SERIAL_SUB_EN for both files to exercise the subtract option.
module tb_serial_add_sequencer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
`ifdef SERIAL_SUB_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         co;
    logic         fa_a, fa_b, fa_ci;
    logic         fa_sum, fa_co;

    int n_cmp = 0;
    int n_bad = 0;

    serial_add_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
`ifdef SERIAL_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co        (co),
        .fa_a      (fa_a),
        .fa_b      (fa_b),
        .fa_ci     (fa_ci),
        .fa_sum    (fa_sum),
        .fa_co     (fa_co)
    );

    // The external single-bit full adder the sequencer drives.
    assign fa_sum = fa_a ^ fa_b ^ fa_ci;
    assign fa_co  = (fa_a & fa_b) | (fa_a & fa_ci) | (fa_b & fa_ci);

    always #5 clk = ~clk;

    // Reference result {co, sum} from plain arithmetic.
    function automatic logic [W:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic c, input logic s);
        if (s) return {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    // Presents one operation and returns at the first cycle with out_valid (out_ready left 0).
    // lat counts the cycle opened by the acceptance edge as cycle 1.
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oci,
                          input logic osb, input bit intrude,
                          output logic [W-1:0] rs, output logic rco, output int lat, output bit ok);
        ok = 0; lat = 0; rs = '0; rco = 1'b0;
        a = oa; b = ob; ci = oci; in_valid = 1'b1;
`ifdef SERIAL_SUB_EN
        sub = osb;
`endif
        for (int i = 0; i < 30; i++) begin
            if (in_ready) break;
            @(posedge clk); #1;
        end
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (intrude) begin
            a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
`ifdef SERIAL_SUB_EN
            sub = 1'($urandom);
`endif
        end else begin
            in_valid = 1'b0;
        end
        for (int n = 2; n < 40; n++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = n; ok = 1; break;
            end
        end
        in_valid = 1'b0;
        rs = sum; rco = co;
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; ci = 1'b0;
`ifdef SERIAL_SUB_EN
        sub = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if ({co, sum} !== '0) begin n_bad++; $display("FAIL reset_sum_co got=%h exp=0", {co, sum}); end
        n_cmp++; if ({fa_a, fa_b, fa_ci} !== 3'b000) begin n_bad++; $display("FAIL reset_fa got=%b exp=000", {fa_a, fa_b, fa_ci}); end
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_directed();
        logic [W-1:0] va[3] = '{8'h5A, 8'hFF, 8'h00};
        logic [W-1:0] vb[3] = '{8'h33, 8'h01, 8'h00};
        logic         vc[3] = '{1'b0, 1'b0, 1'b1};
        logic [W-1:0] es[3] = '{8'h8D, 8'h00, 8'h01};
        logic         ec[3] = '{1'b0, 1'b1, 1'b0};
        logic [W-1:0] rs; logic rco; int lat; bit ok;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], vc[i], 1'b0, 1'b0, rs, rco, lat, ok);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL directed_timeout vec=%0d", i); end
            n_cmp++; if (lat != W + 1) begin n_bad++; $display("FAIL directed_latency vec=%0d got=%0d exp=%0d", i, lat, W + 1); end
            n_cmp++; if (rs !== es[i]) begin n_bad++; $display("FAIL directed_sum vec=%0d got=%h exp=%h", i, rs, es[i]); end
            n_cmp++; if (rco !== ec[i]) begin n_bad++; $display("FAIL directed_co vec=%0d got=%b exp=%b", i, rco, ec[i]); end
            finish_op();
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] oa, ob, rs; logic oc, rco; int lat; bit ok; logic [W:0] e;
        oa = W'($urandom); ob = W'($urandom); oc = 1'($urandom);
        e = ref_op(oa, ob, oc, 1'b0);
        run_op(oa, ob, oc, 1'b0, 1'b0, rs, rco, lat, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_timeout"); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++; if ({out_valid, co, sum} !== {1'b1, e}) begin
                n_bad++; $display("FAIL bp_hold cyc=%0d got=%b/%h exp=1/%h", i, out_valid, {co, sum}, e);
            end
        end
        finish_op();
        n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_bad++; $display("FAIL bp_release got=%b exp=01", {out_valid, in_ready}); end
    endtask

    task automatic test_ignore_in_valid();
        logic [W-1:0] oa, ob, rs; logic oc, rco; int lat; bit ok; logic [W:0] e;
        oa = W'($urandom); ob = W'($urandom); oc = 1'($urandom);
        e = ref_op(oa, ob, oc, 1'b0);
        run_op(oa, ob, oc, 1'b0, 1'b1, rs, rco, lat, ok);
        n_cmp++; if (!ok || {rco, rs} !== e) begin n_bad++; $display("FAIL ignore_in_valid ok=%0d got=%h exp=%h", ok, {rco, rs}, e); end
        finish_op();
    endtask

    task automatic test_midrun_reset();
        logic [W-1:0] oa, ob, rs; logic oc, rco; int lat; bit ok; logic [W:0] e; logic c4;
        oa = W'($urandom); ob = W'($urandom); oc = 1'($urandom);
        c4 = 1'(((32'(oa) & 15) + (32'(ob) & 15) + 32'(oc)) >> 4);
        a = oa; b = ob; ci = oc; in_valid = 1'b1;
`ifdef SERIAL_SUB_EN
        sub = 1'b0;
`endif
        for (int i = 0; i < 30; i++) begin
            if (in_ready) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if ({fa_a, fa_b, fa_ci} !== {oa[4], ob[4], c4}) begin
            n_bad++; $display("FAIL bit4_fa got=%b exp=%b", {fa_a, fa_b, fa_ci}, {oa[4], ob[4], c4});
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if ({in_ready, out_valid, fa_a, fa_b, fa_ci, co, sum} !== '0) begin
            n_bad++; $display("FAIL midrun_reset got rdy=%b vld=%b fa=%b res=%h exp all 0", in_ready, out_valid, {fa_a, fa_b, fa_ci}, {co, sum});
        end
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midrun_reset_idle got=%b exp=1", in_ready); end
        oa = W'($urandom); ob = W'($urandom); oc = 1'($urandom);
        e = ref_op(oa, ob, oc, 1'b0);
        run_op(oa, ob, oc, 1'b0, 1'b0, rs, rco, lat, ok);
        n_cmp++; if (!ok || {rco, rs} !== e) begin n_bad++; $display("FAIL after_reset_op ok=%0d got=%h exp=%h", ok, {rco, rs}, e); end
        finish_op();
    endtask

    task automatic test_random();
        logic [W-1:0] oa, ob, rs; logic oc, os, rco; int lat; bit ok; logic [W:0] e;
        for (int i = 0; i < 20; i++) begin
            oa = W'($urandom); ob = W'($urandom); oc = 1'($urandom);
`ifdef SERIAL_SUB_EN
            os = 1'($urandom);
`else
            os = 1'b0;
`endif
            e = ref_op(oa, ob, oc, os);
            run_op(oa, ob, oc, os, 1'b0, rs, rco, lat, ok);
            n_cmp++; if (!ok || lat != W + 1 || {rco, rs} !== e) begin
                n_bad++; $display("FAIL random it=%0d a=%h b=%h ci=%b sub=%b got=%h lat=%0d exp=%h lat=%0d", i, oa, ob, oc, os, {rco, rs}, lat, e, W + 1);
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            finish_op();
        end
    endtask

    task automatic test_back_to_back();
        logic [W:0] q[$];
        logic [W:0] e;
        int prev = -1;
        out_ready = 1'b1; in_valid = 1'b1;
        a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
`ifdef SERIAL_SUB_EN
        sub = 1'b0;
`endif
        for (int c = 0; c < 60; c++) begin
            bit acc;
            acc = 0;
            if (c == 45) in_valid = 1'b0;
            if (out_valid) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++; $display("FAIL b2b_unexpected got=%h exp=none", {co, sum});
                end else begin
                    e = q.pop_front();
                    if ({co, sum} !== e) begin n_bad++; $display("FAIL b2b_result got=%h exp=%h", {co, sum}, e); end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_op(a, b, ci, 1'b0));
                if (prev >= 0) begin
                    n_cmp++; if (c - prev != W + 2) begin n_bad++; $display("FAIL b2b_interval got=%0d exp=%0d", c - prev, W + 2); end
                end
                prev = c; acc = 1;
            end
            @(posedge clk); #1;
            if (acc) begin a = W'($urandom); b = W'($urandom); ci = 1'($urandom); end
        end
        out_ready = 1'b0;
        n_cmp++; if (q.size() != 0 || prev < 0) begin n_bad++; $display("FAIL b2b_drain left=%0d exp=0", q.size()); end
    endtask

`ifdef SERIAL_SUB_EN
    task automatic test_subtract();
        logic [W-1:0] rs; logic rco; int lat; bit ok;
        run_op(8'h10, 8'h01, 1'b0, 1'b1, 1'b0, rs, rco, lat, ok);
        n_cmp++; if (!ok || {rco, rs} !== 9'h10F) begin n_bad++; $display("FAIL sub_10_01 got=%h exp=10f", {rco, rs}); end
        finish_op();
        run_op(8'h01, 8'h02, 1'b1, 1'b1, 1'b0, rs, rco, lat, ok);
        n_cmp++; if (!ok || {rco, rs} !== 9'h0FF) begin n_bad++; $display("FAIL sub_01_02 got=%h exp=0ff", {rco, rs}); end
        finish_op();
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_ignore_in_valid();
        test_midrun_reset();
        test_random();
        test_back_to_back();
`ifdef SERIAL_SUB_EN
        test_subtract();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
